// File: rtl/bitbang_frame_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : bitbang_frame_assembler
//  Purpose  : Packs the 1-cycle byte strobes of the bit-bang receiver into a
//             fixed-length frame and offers it on a valid/ready handshake.
//             A partial frame that stalls for TIMEOUT_CYCLES byte-free cycles
//             is discarded. Bytes arriving while a finished frame is still
//             held are dropped and reported.
//  Ports    : clk, rst_n          - clock, synchronous active-low reset
//             byte_valid/data     - incoming byte strobe and value
//             frame_valid/data    - complete frame (first byte in the MSBs)
//             frame_ready         - consumer accepts the held frame
//             busy                - state is not IDLE
//             overrun             - pulse: byte dropped while holding
//             timeout_drop        - pulse: partial frame discarded
//  Revision : 1.0 - initial release
// ============================================================================
module bitbang_frame_assembler #(
    parameter int FRAME_BYTES    = 44,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       byte_valid,
    input  logic [7:0]                 byte_data,
    output logic                       frame_valid,
    output logic [8*FRAME_BYTES-1:0]   frame_data,
    input  logic                       frame_ready,
    output logic                       busy,
    output logic                       overrun,
    output logic                       timeout_drop
);

    localparam int W      = 8 * FRAME_BYTES;
    localparam int CNT_W  = $clog2(FRAME_BYTES) + 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    // Count value seen when the final byte of a frame arrives.
    localparam logic [CNT_W-1:0]  C_LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
    // Idle count reached on the last byte-free cycle before the drop.
    localparam logic [IDLE_W-1:0] C_IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        state_q,        state_d;
    logic [CNT_W-1:0]  byte_cnt_q,     byte_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q,     idle_cnt_d;
    logic [W-1:0]      frame_data_q,   frame_data_d;
    logic              overrun_q,      overrun_d;
    logic              timeout_drop_q, timeout_drop_d;
    logic [W-1:0]      w_shifted;

    assign w_shifted = {frame_data_q[W-9:0], byte_data};

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        idle_cnt_d     = idle_cnt_q;
        frame_data_d   = frame_data_q;
        overrun_d      = 1'b0;
        timeout_drop_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                idle_cnt_d = '0;
                if (byte_valid) begin
                    frame_data_d = w_shifted;
                    byte_cnt_d   = CNT_W'(1);
                    state_d      = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (byte_valid) begin
                    // A byte on the expiry cycle is accepted; no drop.
                    frame_data_d = w_shifted;
                    idle_cnt_d   = '0;
                    if (byte_cnt_q == C_LAST_BYTE) begin
                        byte_cnt_d = '0;
                        state_d    = S_HOLD;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end else if (idle_cnt_q == C_IDLE_LAST) begin
                    state_d        = S_IDLE;
                    byte_cnt_d     = '0;
                    idle_cnt_d     = '0;
                    frame_data_d   = '0;
                    timeout_drop_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end

            S_HOLD: begin
                idle_cnt_d = '0;
                if (frame_ready) begin
                    if (byte_valid) begin
                        // Handshake and new byte together: the byte opens
                        // the next frame rather than being lost.
                        frame_data_d = w_shifted;
                        byte_cnt_d   = CNT_W'(1);
                        state_d      = S_COLLECT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (byte_valid) begin
                    overrun_d = 1'b1;
                end
            end

            default: begin
                state_d    = S_IDLE;
                byte_cnt_d = '0;
                idle_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            byte_cnt_q     <= '0;
            idle_cnt_q     <= '0;
            frame_data_q   <= '0;
            overrun_q      <= 1'b0;
            timeout_drop_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            idle_cnt_q     <= idle_cnt_d;
            frame_data_q   <= frame_data_d;
            overrun_q      <= overrun_d;
            timeout_drop_q <= timeout_drop_d;
        end
    end

    assign frame_valid  = (state_q == S_HOLD);
    assign busy         = (state_q != S_IDLE);
    assign frame_data   = frame_data_q;
    assign overrun      = overrun_q;
    assign timeout_drop = timeout_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_bitbang_frame_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitbang_frame_assembler
//  Purpose  : Scoreboard bench for bitbang_frame_assembler (4-byte frames,
//             16-cycle timeout) with directed scenarios and random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bitbang_frame_assembler;

    localparam int FB = 4;
    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        frame_valid;
    logic [31:0] frame_data;
    logic        frame_ready;
    logic        busy;
    logic        overrun;
    logic        timeout_drop;

    bitbang_frame_assembler #(
        .FRAME_BYTES    (FB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .frame_valid  (frame_valid),
        .frame_data   (frame_data),
        .frame_ready  (frame_ready),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_drop (timeout_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic        busy;
        logic        ov;
        logic        to;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] frame_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: bytes of the frame under construction, held frame,
    // and the number of byte-free cycles since the last accepted byte.
    logic [7:0]  m_bytes[$];
    logic        m_holding = 1'b0;
    logic [31:0] m_held    = '0;
    int          m_idle    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rn, input logic bv, input logic [7:0] bd, input logic fr);
        exp_t        e;
        logic [31:0] f;
        e.ov = 1'b0;
        e.to = 1'b0;
        e.chk_data = 1'b0;
        e.data = '0;
        if (!rn) begin
            m_bytes.delete();
            m_holding = 1'b0;
            m_idle    = 0;
            e.chk_data = 1'b1;
        end else if (m_holding) begin
            if (fr) begin
                m_holding = 1'b0;
                if (bv) begin
                    m_bytes.push_back(bd);
                    m_idle = 0;
                end
            end else if (bv) begin
                e.ov = 1'b1;
            end
        end else if (m_bytes.size() > 0) begin
            if (bv) begin
                m_bytes.push_back(bd);
                m_idle = 0;
                if (m_bytes.size() == FB) begin
                    f = '0;
                    foreach (m_bytes[i]) f = {f[23:0], m_bytes[i]};
                    m_held    = f;
                    m_holding = 1'b1;
                    m_bytes.delete();
                    frame_q.push_back(f);
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_bytes.delete();
                    m_idle = 0;
                    e.to = 1'b1;
                    e.chk_data = 1'b1;
                end
            end
        end else if (bv) begin
            m_bytes.push_back(bd);
            m_idle = 0;
        end
        e.fv   = m_holding;
        e.busy = m_holding || (m_bytes.size() > 0);
        if (m_holding) begin
            e.chk_data = 1'b1;
            e.data     = m_held;
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic rn, input logic bv, input logic [7:0] bd, input logic fr);
        @(negedge clk);
        rst_n       = rn;
        byte_valid  = bv;
        byte_data   = bd;
        frame_ready = fr;
        model_step(rn, bv, bd, fr);
    endtask

    task automatic idle(input int n, input logic fr);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, fr);
    endtask

    task automatic send4(input logic [31:0] v, input logic fr);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, v[31-8*i -: 8], fr);
    endtask

    // Monitor: one expectation per edge; frame contents popped on the cycle
    // frame_valid rises.
    logic prev_fv = 1'b0;
    initial begin
        exp_t        e;
        logic [31:0] f;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("frame_valid",  {31'd0, frame_valid},  {31'd0, e.fv});
                chk("busy",         {31'd0, busy},         {31'd0, e.busy});
                chk("overrun",      {31'd0, overrun},      {31'd0, e.ov});
                chk("timeout_drop", {31'd0, timeout_drop}, {31'd0, e.to});
                if (e.chk_data) chk("frame_data_hold_or_clear", frame_data, e.data);
                if (frame_valid === 1'b1 && prev_fv !== 1'b1) begin
                    if (frame_q.size() > 0) begin
                        f = frame_q.pop_front();
                        chk("frame", frame_data, f);
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected none", frame_data);
                    end
                end
            end
            prev_fv = frame_valid;
        end
    end

    initial begin
        int p_bv;
        int p_fr;
        rst_n       = 1'b0;
        byte_valid  = 1'b0;
        byte_data   = 8'h00;
        frame_ready = 1'b0;

        // Reset state
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);

        // Basic frame with 3-cycle gaps
        cyc(1'b1, 1'b1, 8'hA1, 1'b1); idle(3, 1'b1);
        cyc(1'b1, 1'b1, 8'hB2, 1'b1); idle(3, 1'b1);
        cyc(1'b1, 1'b1, 8'hC3, 1'b1); idle(3, 1'b1);
        cyc(1'b1, 1'b1, 8'hD4, 1'b1); idle(3, 1'b1);

        // Held frame and overrun
        send4(32'h1A2B3C4D, 1'b0);
        idle(2, 1'b0);
        cyc(1'b1, 1'b1, 8'hEE, 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);

        // Handshake coincident with a byte
        send4(32'hCAFEF00D, 1'b0);
        idle(1, 1'b0);
        cyc(1'b1, 1'b1, 8'h55, 1'b1);
        cyc(1'b1, 1'b1, 8'h66, 1'b0);
        cyc(1'b1, 1'b1, 8'h77, 1'b0);
        cyc(1'b1, 1'b1, 8'h88, 1'b0);
        idle(1, 1'b0);
        idle(2, 1'b1);

        // Timeout, then a clean frame
        cyc(1'b1, 1'b1, 8'h11, 1'b0);
        cyc(1'b1, 1'b1, 8'h22, 1'b0);
        idle(18, 1'b0);
        send4(32'h01020304, 1'b1);
        idle(2, 1'b1);

        // Timeout race: byte on the expiry cycle wins
        cyc(1'b1, 1'b1, 8'h9A, 1'b1);
        idle(15, 1'b1);
        cyc(1'b1, 1'b1, 8'hBC, 1'b1);
        cyc(1'b1, 1'b1, 8'hDE, 1'b1);
        cyc(1'b1, 1'b1, 8'hF0, 1'b1);
        idle(2, 1'b1);

        // Reset mid-frame and during HOLD
        cyc(1'b1, 1'b1, 8'h31, 1'b0);
        cyc(1'b1, 1'b1, 8'h32, 1'b0);
        cyc(1'b1, 1'b1, 8'h33, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        send4(32'h41424344, 1'b0);
        idle(1, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        send4(32'h51525354, 1'b1);
        idle(2, 1'b1);

        // Random traffic with varying byte density and consumer readiness
        p_bv = 50;
        p_fr = 50;
        for (int n = 0; n < 4000; n++) begin
            if (n % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: p_bv = 100;
                    1: p_bv = 60;
                    2: p_bv = 20;
                    default: p_bv = 5;
                endcase
                p_fr = ($urandom_range(0, 1) == 1) ? 90 : 15;
            end
            cyc(($urandom_range(0, 499) != 0),
                ($urandom_range(0, 99) < p_bv),
                8'($urandom),
                ($urandom_range(0, 99) < p_fr));
        end
        idle(20, 1'b1);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0 || frame_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", exp_q.size(), frame_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bitbang_frame_assembler.md
# bitbang_frame_assembler

Downstream consumer of the bit-bang byte receiver. Collects the 1-cycle byte strobes it emits into a fixed-length frame (default 44 bytes: 32-byte midstate + 12-byte work tail) and presents the whole frame to the miner core on a valid/ready handshake. A frame left incomplete for too long is discarded, which resynchronises a stalled link. Bytes that arrive while a completed frame is still held are dropped and flagged.

## Interface
- FRAME_BYTES, 44, bytes per frame; legal range 2..64
- TIMEOUT_CYCLES, 1000000, consecutive byte-free cycles in COLLECT before the partial frame is discarded; legal minimum 2
- W (derived, not overridable), 8*FRAME_BYTES, frame width
- clk  in  1  sole clock; all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- byte_valid  in  1  1-cycle strobe; byte_data is valid this cycle
- byte_data  in  8  received byte
- frame_valid  out  1  complete frame held on frame_data
- frame_data  out  W  assembled frame; byte 0 (first received) in [W-1:W-8], last byte in [7:0]
- frame_ready  in  1  consumer accepts the frame when frame_valid && frame_ready
- busy  out  1  high whenever state != IDLE
- overrun  out  1  1-cycle pulse: a byte was dropped during HOLD
- timeout_drop  out  1  1-cycle pulse: a partial frame was discarded

## Operation
- States: IDLE, COLLECT, HOLD. Byte counter of width clog2(FRAME_BYTES)+1. Idle counter of width clog2(TIMEOUT_CYCLES).
- Reset (rst_n=0 at an edge): state=IDLE, byte counter 0, idle counter 0, frame_data 0. All outputs 0. Reset takes priority in every state, including mid-frame and HOLD. The partial or held frame is lost.
- Shifting: an accepted byte performs frame_data <= {frame_data[W-9:0], byte_data}.
- IDLE: on byte_valid, shift, count=1, go to COLLECT. No other activity.
- COLLECT, byte_valid=1: shift, count+1, idle counter cleared.
  - If count was FRAME_BYTES-1, go to HOLD and reset count to 0.
- COLLECT, byte_valid=0: idle counter +1.
  - When the idle counter equals TIMEOUT_CYCLES-1, go to IDLE, clear count, idle counter and frame_data, and pulse timeout_drop.
  - If byte_valid arrives on the expiry cycle, the byte wins: it is accepted and there is no drop.
- HOLD: frame_valid=1 and frame_data is stable.
  - Handshake (frame_ready=1) without byte_valid: go to IDLE.
  - Handshake with byte_valid in the same cycle: the byte is the first byte of the next frame. Shift it, count=1, go to COLLECT.
  - byte_valid without frame_ready: byte discarded, overrun pulses, frame_data is unchanged.
- The idle counter runs only in COLLECT and is held at 0 elsewhere.
- frame_ready is ignored outside HOLD.

## Timing
- frame_valid rises on the cycle after the edge that accepts the last byte (1-cycle latency). It falls on the cycle after the handshake edge.
- Minimum frame_valid width is 1 cycle, when frame_ready is held high.
- A back-to-back stream of byte_valid on every cycle is sustained. The only loss is while HOLD is un-acknowledged.
- overrun and timeout_drop assert on the cycle after their causing edge, for exactly 1 cycle.
- busy is registered from the state and has the same timing as the state.
- Timeout fires exactly TIMEOUT_CYCLES byte-free cycles after the last accepted byte.
- The counters never wrap: the byte counter is bounded by FRAME_BYTES, and the idle counter is cleared at expiry.

## Test plan
All scenarios use FRAME_BYTES=4 and TIMEOUT_CYCLES=16.
- **Basic frame:** reset, then bytes 0xA1,0xB2,0xC3,0xD4 with gaps of 3 cycles, frame_ready=1 → frame_valid high for 1 cycle, starting the cycle after the 0xD4 strobe; frame_data=0xA1B2C3D4; busy returns to 0.
- **Held frame and overrun:** frame_ready=0, send 4 bytes, then 0xEE → frame_valid stays high, frame_data=first frame unchanged, overrun pulses once. Raise frame_ready → frame_valid falls the next cycle.
- **Handshake coincident with a byte:** in HOLD, assert frame_ready together with byte_valid 0x55, then send 0x66,0x77,0x88 → the first frame is accepted, with no overrun. The second frame is 0x55667788.
- **Timeout:** send 0x11,0x22, then idle for 16 cycles → timeout_drop pulses once, busy=0. Next, send 0x01..0x04 → frame=0x01020304.
- **Timeout race:** send one byte, then 15 idle cycles, then a byte on the expiry cycle → no timeout_drop, count=2. Complete the frame normally.
- **Reset mid-operation:** pull rst_n low for 1 cycle, once after 3 bytes and once during HOLD → all outputs 0 next cycle. The following 4 bytes form a clean frame.
